// File: rtl/stack_machine_pkg.sv
// Shared opcodes, datapath select encodings and controller state set
// for the stack-machine controller.
package stack_machine_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_POP  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_JZ   = 4'd7;
  localparam logic [3:0] OP_JNZ  = 4'd8;
  localparam logic [3:0] OP_DUP  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_NOT   = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_ALU  = 2'b10;
  localparam logic [1:0] RES_ADR  = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_OFF = 2'b01;
  localparam logic [1:0] SRCB_ONE = 2'b10;

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_LDA, S_LDB, S_EXEC, S_PUSH_RES,
    S_PUSH1, S_PUSH2, S_POP1, S_POP2, S_JZ1, S_JZ2,
    S_JMP1, S_JMP2, S_DUP1, S_DUP2, S_HALT, S_ERR
  } state_t;

  function automatic logic op_legal(input logic [3:0] o);
    return (o <= OP_DUP) || (o == OP_HALT);
  endfunction

endpackage

// File: rtl/stack_depth_tracker.sv
// Stack occupancy counter with the depth compares used by instruction decode.
module stack_depth_tracker #(
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  output logic [DEPTH_W-1:0] depth,
  output logic               empty,
  output logic               lt2,
  output logic               full
);

  logic [DEPTH_W-1:0] depth_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth_reg <= '0;
    end else if (push) begin
      depth_reg <= depth_reg + 1'b1;
    end else if (pop) begin
      depth_reg <= depth_reg - 1'b1;
    end
  end

  assign depth = depth_reg;
  assign empty = (depth_reg == '0);
  assign lt2   = (depth_reg < DEPTH_W'(2));
  assign full  = (depth_reg == DEPTH_W'(STACK_DEPTH));

  // Decode refuses any instruction that could wrap, so these must never fire.
  no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(push && full));
  no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));
  no_push_pop:  assert property (@(posedge clk) disable iff (!rst) !(push && pop));

endmodule

// File: rtl/stack_machine_controller.sv
// Multicycle controller sequencing fetch, decode, ALU, stack and branch
// micro-operations for the stack-machine datapath.
module stack_machine_controller
  import stack_machine_pkg::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         op,
  input  logic               is_zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRwrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               AdrSrc,
  output logic               ldA,
  output logic               ldB,
  output logic               Push,
  output logic               Pop,
  output logic               Tos,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [DEPTH_W-1:0] depth,
  output logic               Done,
  output logic               Err
);

  state_t state_reg, state_next;
  logic   depth_empty, depth_lt2, depth_full;
  logic   needs_two, needs_one, grows;

  stack_depth_tracker #(
    .STACK_DEPTH(STACK_DEPTH),
    .DEPTH_W    (DEPTH_W)
  ) u_depth (
    .clk  (clk),
    .rst  (rst),
    .push (Push),
    .pop  (Pop),
    .depth(depth),
    .empty(depth_empty),
    .lt2  (depth_lt2),
    .full (depth_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_FETCH;
    else      state_reg <= state_next;
  end

  assign needs_two = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  assign needs_one = (op == OP_NOT) || (op == OP_POP) || (op == OP_JZ) ||
                     (op == OP_JNZ) || (op == OP_DUP);
  assign grows     = (op == OP_PUSH) || (op == OP_DUP);

  always_comb begin
    state_next = state_reg;
    PCWrite    = 1'b0;
    IRwrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ldA        = 1'b0;
    ldB        = 1'b0;
    Push       = 1'b0;
    Pop        = 1'b0;
    Tos        = 1'b0;
    ResultSrc  = RES_NONE;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    ALUControl = ALU_ADD;
    Done       = 1'b0;
    Err        = 1'b0;

    case (state_reg)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = SRCB_ONE;
        ResultSrc = RES_ALU;
        if (mem_ready) begin
          IRwrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!op_legal(op))                state_next = S_ERR;
        else if (needs_two && depth_lt2)  state_next = S_ERR;
        else if (needs_one && depth_empty) state_next = S_ERR;
        else if (grows && depth_full)     state_next = S_ERR;
        else begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_NOT: state_next = S_LDA;
            OP_PUSH:                        state_next = S_PUSH1;
            OP_POP:                         state_next = S_POP1;
            OP_JMP:                         state_next = S_JMP1;
            OP_JZ, OP_JNZ:                  state_next = S_JZ1;
            OP_DUP:                         state_next = S_DUP1;
            OP_HALT:                        state_next = S_HALT;
            default:                        state_next = S_ERR;
          endcase
        end
      end
      S_LDA: begin
        Pop        = 1'b1;
        ldA        = 1'b1;
        state_next = (op == OP_NOT) ? S_EXEC : S_LDB;
      end
      S_LDB: begin
        Pop        = 1'b1;
        ldB        = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_B;
        case (op)
          OP_SUB:  ALUControl = ALU_SUB;
          OP_AND:  ALUControl = ALU_AND;
          OP_NOT:  ALUControl = ALU_NOT;
          default: ALUControl = ALU_ADD;
        endcase
        state_next = S_PUSH_RES;
      end
      S_PUSH_RES: begin
        ResultSrc  = RES_ALU;
        Push       = 1'b1;
        state_next = S_FETCH;
      end
      S_PUSH1: begin
        MemRead   = 1'b1;
        AdrSrc    = 1'b1;
        ResultSrc = RES_ADR;
        if (mem_ready) state_next = S_PUSH2;
      end
      S_PUSH2: begin
        ResultSrc  = RES_MEM;
        Push       = 1'b1;
        state_next = S_FETCH;
      end
      S_POP1: begin
        Pop        = 1'b1;
        ldB        = 1'b1;
        state_next = S_POP2;
      end
      S_POP2: begin
        MemWrite  = 1'b1;
        AdrSrc    = 1'b1;
        ResultSrc = RES_ADR;
        if (mem_ready) state_next = S_FETCH;
      end
      S_JZ1, S_DUP1: begin
        Tos        = 1'b1;
        ldB        = 1'b1;
        state_next = (state_reg == S_JZ1) ? S_JZ2 : S_DUP2;
      end
      S_JZ2: begin
        ALUControl = ALU_PASSB;
        if (((op == OP_JZ) && is_zero) || ((op == OP_JNZ) && !is_zero))
          state_next = S_JMP1;
        else
          state_next = S_FETCH;
      end
      S_JMP1: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_OFF;
        ALUControl = ALU_ADD;
        state_next = S_JMP2;
      end
      S_JMP2: begin
        ResultSrc  = RES_ALU;
        PCWrite    = 1'b1;
        state_next = S_FETCH;
      end
      S_DUP2: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        ALUControl = ALU_PASSB;
        state_next = S_PUSH_RES;
      end
      S_HALT:  Done = 1'b1;
      S_ERR:   Err  = 1'b1;
      default: state_next = S_ERR;
    endcase

    // Reset forces every control low even though the state already reads FETCH.
    if (!rst) begin
      PCWrite    = 1'b0;
      IRwrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ldA        = 1'b0;
      ldB        = 1'b0;
      Push       = 1'b0;
      Pop        = 1'b0;
      Tos        = 1'b0;
      ResultSrc  = RES_NONE;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_B;
      ALUControl = ALU_ADD;
      Done       = 1'b0;
      Err        = 1'b0;
    end
  end

endmodule
